// File: rtl/commit_monitor_pkg.sv
// Shared types and helpers for the commit monitor: the commit entry record,
// the default trap encoding, the monitor state enum and a popcount helper.
package commit_monitor_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        skip;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
  } commit_entry_t;

  localparam logic [31:0] TRAP_INSTR_DEF = 32'h0000_006b;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_HALT = 2'd2
  } mon_state_t;

  // Lane masks are at most 4 bits wide; callers zero-extend to 8.
  function automatic int unsigned popcount(input logic [7:0] v);
    popcount = 0;
    for (int i = 0; i < 8; i++) popcount += {31'd0, v[i]};
  endfunction

endpackage

// File: rtl/commit_fifo_mw.sv
// Multi-write / multi-read circular buffer: pushes a packed group of lanes at
// wptr, exposes NOUT head entries combinationally, retires pop_n per cycle.
module commit_fifo_mw
  import commit_monitor_pkg::*;
#(
  parameter int NIN   = 2,
  parameter int NOUT  = 2,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_en,
  input  logic [NIN-1:0]                push_valid,
  input  commit_entry_t [NIN-1:0]       push_entry,
  input  logic [$clog2(DEPTH):0]        pop_n,
  output logic [$clog2(DEPTH):0]        occ,
  output commit_entry_t [NOUT-1:0]      head_entry
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  commit_entry_t mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [OW-1:0] push_n;

  assign push_n = push_en ? OW'(popcount(8'(push_valid))) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rptr <= '0;
      wptr <= '0;
      occ  <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (push_en && push_valid[i]) mem[wptr + AW'(i)] <= push_entry[i];
      end
      wptr <= wptr + push_n[AW-1:0];
      rptr <= rptr + pop_n[AW-1:0];
      occ  <= occ + push_n - pop_n;
    end
  end

  always_comb begin
    for (int j = 0; j < NOUT; j++) head_entry[j] = mem[rptr + AW'(j)];
  end

endmodule

// File: rtl/commit_monitor.sv
// Commit buffer between writeback and the difftest commit/trap ports: gates
// pushes and pops, detects the trap instruction, keeps cycle/instr counters.
module commit_monitor
  import commit_monitor_pkg::*;
#(
  parameter int          NIN        = 2,
  parameter int          NOUT       = 2,
  parameter int          DEPTH      = 8,
  parameter logic [31:0] TRAP_INSTR = TRAP_INSTR_DEF,
  parameter int          CNT_W      = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NIN-1:0]           in_valid,
  input  commit_entry_t [NIN-1:0]  in_entry,
  output logic                     in_ready,
  input  logic [63:0]              gpr_a0,
  output logic [NOUT-1:0]          out_valid,
  output commit_entry_t [NOUT-1:0] out_entry,
  input  logic                     out_ready,
  output logic                     trap_valid,
  output logic [2:0]               trap_code,
  output logic [63:0]              trap_pc,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         instr_cnt,
  output logic                     halted,
  output logic                     lane_err,
  output mon_state_t               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  // Handshake: a push happens on a clock edge where in_ready is high; every
  // set in_valid lane is taken. A pop happens on an edge where out_ready is
  // high; every set out_valid lane is taken. Neither valid depends on ready.

  mon_state_t    state_d;
  logic [OW-1:0] occ;
  logic [OW-1:0] pop_n;
  logic          packed_ok;
  logic          trap_hit;
  logic [63:0]   trap_pc_d;
  logic          unused_a0;

  assign unused_a0 = ^gpr_a0[63:3];
  assign halted    = (state != ST_RUN);
  assign trap_valid = (state == ST_TRAP);
  // A lane-packed mask is a run of ones from bit 0, so mask & (mask+1) is zero.
  assign packed_ok = ((in_valid & (in_valid + NIN'(1))) == '0);
  assign in_ready  = !halted && (int'(occ) <= DEPTH - NIN);

  commit_fifo_mw #(.NIN(NIN), .NOUT(NOUT), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_en    (in_ready && packed_ok),
    .push_valid (in_valid),
    .push_entry (in_entry),
    .pop_n      (pop_n),
    .occ        (occ),
    .head_entry (out_entry)
  );

  always_comb begin
    for (int j = 0; j < NOUT; j++) out_valid[j] = (int'(occ) > j) && !halted;
  end

  // Retire lanes in order; the first trap lane retires and stops the scan.
  always_comb begin
    pop_n     = '0;
    trap_hit  = 1'b0;
    trap_pc_d = '0;
    if (out_ready) begin
      for (int j = 0; j < NOUT; j++) begin
        if (out_valid[j] && !trap_hit) begin
          pop_n = pop_n + OW'(1);
          if (out_entry[j].instr == TRAP_INSTR) begin
            trap_hit  = 1'b1;
            trap_pc_d = out_entry[j].pc;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_RUN:  if (trap_hit) state_d = ST_TRAP;
      ST_TRAP: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      trap_pc   <= '0;
      trap_code <= '0;
      lane_err  <= 1'b0;
    end else begin
      state     <= state_d;
      instr_cnt <= instr_cnt + CNT_W'(pop_n);
      if (!halted) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (!packed_ok) lane_err <= 1'b1;
      if (trap_hit) begin
        trap_pc   <= trap_pc_d;
        trap_code <= gpr_a0[2:0];
      end
    end
  end

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor: fill/stall, streaming with wrap, trap in
// either lane, lane-packing error and asynchronous reset with a partly full FIFO.
module tb_commit_monitor;
  import commit_monitor_pkg::*;

  localparam logic [31:0] ADDI = 32'h0000_0513;
  localparam logic [31:0] TRAP = 32'h0000_006b;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         in_valid;
  commit_entry_t [1:0] in_entry;
  logic               in_ready;
  logic [63:0]        gpr_a0;
  logic [1:0]         out_valid;
  commit_entry_t [1:0] out_entry;
  logic               out_ready;
  logic               trap_valid;
  logic [2:0]         trap_code;
  logic [63:0]        trap_pc;
  logic [63:0]        cycle_cnt;
  logic [63:0]        instr_cnt;
  logic               halted;
  logic               lane_err;
  mon_state_t         state;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          m_occ;
  logic [63:0] m_cnt;
  logic [63:0] m_cyc;
  logic [63:0] next_pc;
  logic [63:0] saved;

  always #5 clk = ~clk;

  commit_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_entry   (in_entry),
    .in_ready   (in_ready),
    .gpr_a0     (gpr_a0),
    .out_valid  (out_valid),
    .out_entry  (out_entry),
    .out_ready  (out_ready),
    .trap_valid (trap_valid),
    .trap_code  (trap_code),
    .trap_pc    (trap_pc),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt),
    .halted     (halted),
    .lane_err   (lane_err),
    .state      (state)
  );

  function automatic commit_entry_t mk(input logic [63:0] pc, input logic [31:0] instr);
    mk       = '0;
    mk.pc    = pc;
    mk.instr = instr;
    mk.wen   = 1'b1;
    mk.wdest = 8'd10;
    mk.wdata = pc ^ 64'h5a5a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 2'b00;
    in_entry  = '0;
    out_ready = 1'b0;
    gpr_a0    = '0;
    cyc();
    reset   = 1'b0;
    m_occ   = 0;
    m_cnt   = '0;
    m_cyc   = '0;
    next_pc = 64'h8000_0000;
    exp_q.delete();
  endtask

  // One clock of paired-lane traffic checked against a small occupancy model.
  task automatic step(input bit feed);
    int npop;
    int npush;
    in_valid    = feed ? 2'b11 : 2'b00;
    in_entry[0] = mk(next_pc, ADDI);
    in_entry[1] = mk(next_pc + 64'd4, ADDI);
    check("in_ready", {63'd0, in_ready}, {63'd0, (8 - m_occ) >= 2});
    check("out_valid", {62'd0, out_valid},
          m_occ >= 2 ? 64'd3 : (m_occ == 1 ? 64'd1 : 64'd0));
    npop = out_ready ? ((m_occ < 2) ? m_occ : 2) : 0;
    for (int j = 0; j < npop; j++) check("out_pc", out_entry[j].pc, exp_q.pop_front());
    npush = (feed && (8 - m_occ) >= 2) ? 2 : 0;
    for (int i = 0; i < npush; i++) exp_q.push_back(next_pc + 64'(4 * i));
    next_pc = next_pc + 64'(4 * npush);
    m_occ   = m_occ + npush - npop;
    m_cnt   = m_cnt + 64'(npop);
    m_cyc   = m_cyc + 64'd1;
    cyc();
    check("instr_cnt", instr_cnt, m_cnt);
    check("cycle_cnt", cycle_cnt, m_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state, sampled while reset is still asserted.
    reset = 1'b1; in_valid = 2'b00; in_entry = '0; out_ready = 1'b0; gpr_a0 = '0;
    cyc();
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {62'd0, out_valid}, 64'd0);
    check("rst_cycle_cnt", cycle_cnt, 64'd0);
    check("rst_instr_cnt", instr_cnt, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_lane_err", {63'd0, lane_err}, 64'd0);
    check("rst_trap_valid", {63'd0, trap_valid}, 64'd0);
    check("rst_out_entry", out_entry[0].pc, 64'd0);
    do_reset();

    // First pair lands and is visible next cycle.
    step(1'b1);
    check("t1_out_valid", {62'd0, out_valid}, 64'd3);
    check("t1_pc0", out_entry[0].pc, 64'h8000_0000);
    check("t1_pc1", out_entry[1].pc, 64'h8000_0004);

    // Fill to 8, then one held push, then drain two per cycle.
    repeat (3) step(1'b1);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    step(1'b1);
    check("held_head", out_entry[0].pc, 64'h8000_0000);
    out_ready = 1'b1;
    step(1'b1);
    check("reopen_in_ready", {63'd0, in_ready}, 64'd1);

    // Streaming push 2 / pop 2 across pointer wrap.
    saved = instr_cnt;
    repeat (20) step(1'b1);
    check("stream_cnt", instr_cnt, saved + 64'd40);
    repeat (3) step(1'b0);
    check("drained", {62'd0, out_valid}, 64'd0);

    // Trap in lane 1 with a0 = 0.
    saved = instr_cnt;
    out_ready = 1'b0; in_valid = 2'b11;
    in_entry[0] = mk(64'h8000_000c, ADDI);
    in_entry[1] = mk(64'h8000_0010, TRAP);
    cyc();
    in_valid = 2'b00; out_ready = 1'b1;
    cyc();
    check("trap_valid", {63'd0, trap_valid}, 64'd1);
    check("trap_pc", trap_pc, 64'h8000_0010);
    check("trap_code", {61'd0, trap_code}, 64'd0);
    check("trap_halted", {63'd0, halted}, 64'd1);
    check("trap_cnt", instr_cnt, saved + 64'd2);
    check("trap_in_ready", {63'd0, in_ready}, 64'd0);
    check("trap_cycle", cycle_cnt, m_cyc + 64'd2);
    in_valid = 2'b11;
    cyc();
    check("trap_pulse_end", {63'd0, trap_valid}, 64'd0);
    check("halt_state", {62'd0, state}, {62'd0, ST_HALT});
    check("halt_pc_hold", trap_pc, 64'h8000_0010);
    check("halt_cycle", cycle_cnt, m_cyc + 64'd2);
    check("halt_cnt", instr_cnt, saved + 64'd2);
    check("halt_out_valid", {62'd0, out_valid}, 64'd0);
    check("halt_in_ready", {63'd0, in_ready}, 64'd0);

    // Reset leaves halt; a non-packed mask flags lane_err and pushes nothing.
    do_reset();
    check("rearm_halted", {63'd0, halted}, 64'd0);
    in_valid = 2'b10; in_entry[1] = mk(64'h9000_0000, ADDI);
    cyc();
    in_valid = 2'b00;
    check("lane_err", {63'd0, lane_err}, 64'd1);
    check("lane_err_nopush", {62'd0, out_valid}, 64'd0);
    cyc();
    check("lane_err_sticky", {63'd0, lane_err}, 64'd1);

    // Occupancy 5, then asynchronous reset mid-cycle.
    in_valid = 2'b11;
    in_entry[0] = mk(64'h8000_0040, ADDI);
    in_entry[1] = mk(64'h8000_0044, ADDI);
    cyc();
    cyc();
    in_valid = 2'b01;
    cyc();
    in_valid = 2'b00;
    check("occ5_out_valid", {62'd0, out_valid}, 64'd3);
    check("occ5_in_ready", {63'd0, in_ready}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_out_valid", {62'd0, out_valid}, 64'd0);
    check("async_in_ready", {63'd0, in_ready}, 64'd1);
    check("async_lane_err", {63'd0, lane_err}, 64'd0);
    check("async_cycle", cycle_cnt, 64'd0);
    do_reset();

    // Trap in lane 0 discards lane 1; a0 low bits = 5.
    in_valid = 2'b11;
    in_entry[0] = mk(64'h8000_0100, TRAP);
    in_entry[1] = mk(64'h8000_0104, ADDI);
    gpr_a0 = 64'h0000_00fd;
    cyc();
    in_valid = 2'b00; out_ready = 1'b1;
    cyc();
    gpr_a0 = '0;
    check("trap0_valid", {63'd0, trap_valid}, 64'd1);
    check("trap0_pc", trap_pc, 64'h8000_0100);
    check("trap0_code", {61'd0, trap_code}, 64'd5);
    check("trap0_cnt", instr_cnt, 64'd1);
    cyc();
    check("trap0_cnt_hold", instr_cnt, 64'd1);
    check("trap0_code_hold", {61'd0, trap_code}, 64'd5);
    check("trap0_out_valid", {62'd0, out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
